// File: rtl/rvfi_commit_tracker_if.sv
// Writeback-to-RVFI bundle: retire info from the writeback stage and the registered RVFI view.
// The writeback side (master) drives wb_*; the tracker (slave) drives rvfi_*.
interface rvfi_commit_tracker_if #(
    parameter int ORDER_W = 64
);
    logic               wb_valid;
    logic               wb_flush;
    logic [31:0]        wb_inst;
    logic               wb_trap;
    logic [31:0]        wb_pc;
    logic [31:0]        wb_next_pc;
    logic [4:0]         wb_rs1_addr;
    logic [4:0]         wb_rs2_addr;
    logic [31:0]        wb_rs1_rdata;
    logic [31:0]        wb_rs2_rdata;
    logic               wb_load_rf;
    logic [4:0]         wb_rd_addr;
    logic [31:0]        wb_rd_wdata;
    logic [31:0]        wb_mem_addr;
    logic [3:0]         wb_mem_rmask;
    logic [3:0]         wb_mem_wmask;
    logic [31:0]        wb_mem_rdata;
    logic [31:0]        wb_mem_wdata;

    logic               rvfi_commit;
    logic [ORDER_W-1:0] rvfi_order;
    logic               rvfi_halt;
    logic [15:0]        rvfi_errcode;
    logic [31:0]        rvfi_inst;
    logic               rvfi_trap;
    logic [31:0]        rvfi_pc_rdata;
    logic [31:0]        rvfi_pc_wdata;
    logic [4:0]         rvfi_rs1_addr;
    logic [4:0]         rvfi_rs2_addr;
    logic [31:0]        rvfi_rs1_rdata;
    logic [31:0]        rvfi_rs2_rdata;
    logic               rvfi_load_regfile;
    logic [4:0]         rvfi_rd_addr;
    logic [31:0]        rvfi_rd_wdata;
    logic [31:0]        rvfi_mem_addr;
    logic [3:0]         rvfi_mem_rmask;
    logic [3:0]         rvfi_mem_wmask;
    logic [31:0]        rvfi_mem_rdata;
    logic [31:0]        rvfi_mem_wdata;

    modport master (
        output wb_valid, wb_flush, wb_inst, wb_trap, wb_pc, wb_next_pc,
               wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
               wb_load_rf, wb_rd_addr, wb_rd_wdata,
               wb_mem_addr, wb_mem_rmask, wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
        input  rvfi_commit, rvfi_order, rvfi_halt, rvfi_errcode, rvfi_inst, rvfi_trap,
               rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input  wb_valid, wb_flush, wb_inst, wb_trap, wb_pc, wb_next_pc,
               wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
               wb_load_rf, wb_rd_addr, wb_rd_wdata,
               wb_mem_addr, wb_mem_rmask, wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
        output rvfi_commit, rvfi_order, rvfi_halt, rvfi_errcode, rvfi_inst, rvfi_trap,
               rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr,
               rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               rvfi_mem_rdata, rvfi_mem_wdata
    );
endinterface

// File: rtl/rvfi_commit_tracker.sv
// Retirement stage: registers writeback retire info onto RVFI with an order number,
// detects the branch-to-self program end, and latches the first PC-continuity/trap/halt error.
module rvfi_commit_tracker #(
    parameter int          ORDER_W     = 64,
    parameter int          HALT_REPEAT = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0060
) (
    input logic                  clk,
    input logic                  rst,
    rvfi_commit_tracker_if.slave bus
);
    localparam int CNT_W = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0] HALT_N = CNT_W'(HALT_REPEAT);

    typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

    state_t             state;
    logic [CNT_W-1:0]   loop_cnt;
    logic [ORDER_W-1:0] order_cnt;
    logic [31:0]        expected_pc;
    logic               retire;
    logic               self_loop;
    logic               pc_err;
    logic               valid_while_halted;

    assign retire             = bus.wb_valid & ~bus.wb_flush & (state != HALTED);
    assign valid_while_halted = bus.wb_valid & ~bus.wb_flush & (state == HALTED);
    assign self_loop          = (bus.wb_next_pc == bus.wb_pc);
    assign pc_err             = (bus.wb_pc != expected_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= RUN;
            loop_cnt              <= '0;
            order_cnt             <= '0;
            expected_pc           <= RESET_PC;
            bus.rvfi_commit       <= 1'b0;
            bus.rvfi_order        <= '0;
            bus.rvfi_halt         <= 1'b0;
            bus.rvfi_errcode      <= 16'd0;
            bus.rvfi_inst         <= 32'd0;
            bus.rvfi_trap         <= 1'b0;
            bus.rvfi_pc_rdata     <= 32'd0;
            bus.rvfi_pc_wdata     <= 32'd0;
            bus.rvfi_rs1_addr     <= 5'd0;
            bus.rvfi_rs2_addr     <= 5'd0;
            bus.rvfi_rs1_rdata    <= 32'd0;
            bus.rvfi_rs2_rdata    <= 32'd0;
            bus.rvfi_load_regfile <= 1'b0;
            bus.rvfi_rd_addr      <= 5'd0;
            bus.rvfi_rd_wdata     <= 32'd0;
            bus.rvfi_mem_addr     <= 32'd0;
            bus.rvfi_mem_rmask    <= 4'd0;
            bus.rvfi_mem_wmask    <= 4'd0;
            bus.rvfi_mem_rdata    <= 32'd0;
            bus.rvfi_mem_wdata    <= 32'd0;
        end else begin
            bus.rvfi_commit <= retire;
            if (retire) begin
                bus.rvfi_order        <= order_cnt;
                order_cnt             <= order_cnt + ORDER_W'(1);
                expected_pc           <= bus.wb_next_pc;
                bus.rvfi_inst         <= bus.wb_inst;
                bus.rvfi_trap         <= bus.wb_trap;
                bus.rvfi_pc_rdata     <= bus.wb_pc;
                bus.rvfi_pc_wdata     <= bus.wb_next_pc;
                bus.rvfi_rs1_addr     <= bus.wb_rs1_addr;
                bus.rvfi_rs2_addr     <= bus.wb_rs2_addr;
                bus.rvfi_rs1_rdata    <= bus.wb_rs1_rdata;
                bus.rvfi_rs2_rdata    <= bus.wb_rs2_rdata;
                bus.rvfi_load_regfile <= bus.wb_load_rf;
                bus.rvfi_rd_addr      <= bus.wb_rd_addr;
                // x0 never holds a value, so its write data is reported as zero
                bus.rvfi_rd_wdata     <= (bus.wb_rd_addr == 5'd0) ? 32'd0 : bus.wb_rd_wdata;
                bus.rvfi_mem_addr     <= bus.wb_mem_addr;
                bus.rvfi_mem_rmask    <= bus.wb_mem_rmask;
                bus.rvfi_mem_wmask    <= bus.wb_mem_wmask;
                bus.rvfi_mem_rdata    <= bus.wb_mem_rdata;
                bus.rvfi_mem_wdata    <= bus.wb_mem_wdata;

                // Continuity error takes precedence over a trap on the same commit
                if (bus.rvfi_errcode == 16'd0) begin
                    if (pc_err)
                        bus.rvfi_errcode <= 16'd1;
                    else if (bus.wb_trap)
                        bus.rvfi_errcode <= 16'd2;
                end

                case (state)
                    RUN: begin
                        if (self_loop) begin
                            loop_cnt <= CNT_W'(1);
                            if (HALT_N == CNT_W'(1)) begin
                                state         <= HALTED;
                                bus.rvfi_halt <= 1'b1;
                            end else begin
                                state <= PEND;
                            end
                        end
                    end
                    PEND: begin
                        if (self_loop) begin
                            loop_cnt <= loop_cnt + CNT_W'(1);
                            if (loop_cnt + CNT_W'(1) == HALT_N) begin
                                state         <= HALTED;
                                bus.rvfi_halt <= 1'b1;
                            end
                        end else begin
                            state    <= RUN;
                            loop_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end else if (valid_while_halted && bus.rvfi_errcode == 16'd0) begin
                bus.rvfi_errcode <= 16'd3;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed bench for rvfi_commit_tracker: ordering, continuity, trap, halt FSM, flush, x0 sanitising, reset.
module tb_rvfi_commit_tracker;
    logic clk;
    logic rst;
    int   asserts;
    int   failures;

    rvfi_commit_tracker_if #(.ORDER_W(64)) bus ();

    rvfi_commit_tracker #(
        .ORDER_W    (64),
        .HALT_REPEAT(2),
        .RESET_PC   (32'h0000_0060)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid     = 1'b0;
        bus.wb_flush     = 1'b0;
        bus.wb_inst      = 32'd0;
        bus.wb_trap      = 1'b0;
        bus.wb_pc        = 32'd0;
        bus.wb_next_pc   = 32'd0;
        bus.wb_rs1_addr  = 5'd0;
        bus.wb_rs2_addr  = 5'd0;
        bus.wb_rs1_rdata = 32'd0;
        bus.wb_rs2_rdata = 32'd0;
        bus.wb_load_rf   = 1'b0;
        bus.wb_rd_addr   = 5'd0;
        bus.wb_rd_wdata  = 32'd0;
        bus.wb_mem_addr  = 32'd0;
        bus.wb_mem_rmask = 4'd0;
        bus.wb_mem_wmask = 4'd0;
        bus.wb_mem_rdata = 32'd0;
        bus.wb_mem_wdata = 32'd0;
    endtask

    task automatic drive(input logic flush, input logic [31:0] pc, input logic [31:0] next_pc,
                         input logic trap);
        bus.wb_valid   = 1'b1;
        bus.wb_flush   = flush;
        bus.wb_pc      = pc;
        bus.wb_next_pc = next_pc;
        bus.wb_trap    = trap;
        bus.wb_inst    = 32'h0000_0013 ^ pc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (5) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        asserts++;
        if (bus.rvfi_commit !== 1'b0) begin
            failures++; $display("FAIL reset_commit: got %0h want 0", bus.rvfi_commit);
        end
        asserts++;
        if (bus.rvfi_order !== 64'd0) begin
            failures++; $display("FAIL reset_order: got %0h want 0", bus.rvfi_order);
        end
        asserts++;
        if (bus.rvfi_halt !== 1'b0 || bus.rvfi_errcode !== 16'd0) begin
            failures++; $display("FAIL reset_halt_err: got halt=%0h err=%0h want 0/0", bus.rvfi_halt, bus.rvfi_errcode);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h60; pcs[1] = 32'h64; pcs[2] = 32'h68;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, pcs[i], pcs[i] + 32'd4, 1'b0);
            step();
            asserts++;
            if (bus.rvfi_commit !== 1'b1 || bus.rvfi_order !== 64'(i)) begin
                failures++; $display("FAIL b2b_commit_order%0d: got c=%0h o=%0h want 1/%0h", i, bus.rvfi_commit, bus.rvfi_order, i);
            end
            asserts++;
            if (bus.rvfi_pc_rdata !== pcs[i] || bus.rvfi_pc_wdata !== pcs[i] + 32'd4) begin
                failures++; $display("FAIL b2b_pc%0d: got %0h/%0h want %0h/%0h", i, bus.rvfi_pc_rdata, bus.rvfi_pc_wdata, pcs[i], pcs[i] + 32'd4);
            end
        end
        idle();
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b0 || bus.rvfi_order !== 64'd2 || bus.rvfi_errcode !== 16'd0) begin
            failures++; $display("FAIL b2b_idle: got c=%0h o=%0h e=%0h want 0/2/0", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_errcode);
        end
        asserts++;
        if (bus.rvfi_pc_rdata !== 32'h68) begin
            failures++; $display("FAIL b2b_hold: got %0h want 68", bus.rvfi_pc_rdata);
        end
    endtask

    task automatic test_continuity();
        do_reset();
        drive(1'b0, 32'h60, 32'h64, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_errcode !== 16'd0) begin
            failures++; $display("FAIL cont_first: got %0h want 0", bus.rvfi_errcode);
        end
        drive(1'b0, 32'h70, 32'h74, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_errcode !== 16'd1 || bus.rvfi_commit !== 1'b1 || bus.rvfi_order !== 64'd1) begin
            failures++; $display("FAIL cont_gap: got e=%0h c=%0h o=%0h want 1/1/1", bus.rvfi_errcode, bus.rvfi_commit, bus.rvfi_order);
        end
        drive(1'b0, 32'h90, 32'h94, 1'b1);
        step();
        asserts++;
        if (bus.rvfi_errcode !== 16'd1 || bus.rvfi_trap !== 1'b1) begin
            failures++; $display("FAIL cont_sticky: got e=%0h t=%0h want 1/1", bus.rvfi_errcode, bus.rvfi_trap);
        end
    endtask

    task automatic test_trap();
        do_reset();
        drive(1'b0, 32'h60, 32'h64, 1'b1);
        step();
        asserts++;
        if (bus.rvfi_errcode !== 16'd2 || bus.rvfi_commit !== 1'b1 || bus.rvfi_trap !== 1'b1) begin
            failures++; $display("FAIL trap_code: got e=%0h c=%0h t=%0h want 2/1/1", bus.rvfi_errcode, bus.rvfi_commit, bus.rvfi_trap);
        end
        drive(1'b0, 32'h64, 32'h68, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_errcode !== 16'd2 || bus.rvfi_order !== 64'd1) begin
            failures++; $display("FAIL trap_continue: got e=%0h o=%0h want 2/1", bus.rvfi_errcode, bus.rvfi_order);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b0, 32'h60, 32'h80, 1'b0);
        step();
        drive(1'b0, 32'h80, 32'h80, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_halt !== 1'b0 || bus.rvfi_commit !== 1'b1) begin
            failures++; $display("FAIL halt_first_loop: got h=%0h c=%0h want 0/1", bus.rvfi_halt, bus.rvfi_commit);
        end
        step();
        asserts++;
        if (bus.rvfi_halt !== 1'b1 || bus.rvfi_commit !== 1'b1 || bus.rvfi_order !== 64'd2 || bus.rvfi_errcode !== 16'd0) begin
            failures++; $display("FAIL halt_assert: got h=%0h c=%0h o=%0h e=%0h want 1/1/2/0", bus.rvfi_halt, bus.rvfi_commit, bus.rvfi_order, bus.rvfi_errcode);
        end
        drive(1'b0, 32'h80, 32'h84, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b0 || bus.rvfi_order !== 64'd2 || bus.rvfi_errcode !== 16'd3 || bus.rvfi_halt !== 1'b1) begin
            failures++; $display("FAIL halt_ignore: got c=%0h o=%0h e=%0h h=%0h want 0/2/3/1", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_errcode, bus.rvfi_halt);
        end
        asserts++;
        if (bus.rvfi_pc_wdata !== 32'h80) begin
            failures++; $display("FAIL halt_frozen_data: got %0h want 80", bus.rvfi_pc_wdata);
        end
        idle();
    endtask

    task automatic test_loop_break();
        do_reset();
        drive(1'b0, 32'h60, 32'h80, 1'b0);
        step();
        drive(1'b0, 32'h80, 32'h80, 1'b0);
        step();
        drive(1'b0, 32'h84, 32'h88, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_halt !== 1'b0 || bus.rvfi_errcode !== 16'd1) begin
            failures++; $display("FAIL loop_break: got h=%0h e=%0h want 0/1", bus.rvfi_halt, bus.rvfi_errcode);
        end
        drive(1'b0, 32'h88, 32'h88, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_halt !== 1'b0) begin
            failures++; $display("FAIL loop_restart: got %0h want 0", bus.rvfi_halt);
        end
        step();
        asserts++;
        if (bus.rvfi_halt !== 1'b1 || bus.rvfi_order !== 64'd4) begin
            failures++; $display("FAIL loop_halt: got h=%0h o=%0h want 1/4", bus.rvfi_halt, bus.rvfi_order);
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b0, 32'h60, 32'h64, 1'b0);
        step();
        drive(1'b1, 32'h64, 32'h64, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b0 || bus.rvfi_order !== 64'd0 || bus.rvfi_pc_rdata !== 32'h60) begin
            failures++; $display("FAIL flush_drop: got c=%0h o=%0h pc=%0h want 0/0/60", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_pc_rdata);
        end
        drive(1'b0, 32'h64, 32'h68, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b1 || bus.rvfi_order !== 64'd1 || bus.rvfi_errcode !== 16'd0 || bus.rvfi_halt !== 1'b0) begin
            failures++; $display("FAIL flush_next: got c=%0h o=%0h e=%0h h=%0h want 1/1/0/0", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_errcode, bus.rvfi_halt);
        end
    endtask

    task automatic test_rd_and_async_reset();
        do_reset();
        drive(1'b0, 32'h60, 32'h64, 1'b0);
        bus.wb_load_rf  = 1'b1;
        bus.wb_rd_addr  = 5'd0;
        bus.wb_rd_wdata = 32'hDEAD_BEEF;
        step();
        asserts++;
        if (bus.rvfi_rd_wdata !== 32'd0 || bus.rvfi_load_regfile !== 1'b1 || bus.rvfi_rd_addr !== 5'd0) begin
            failures++; $display("FAIL rd_x0: got w=%0h l=%0h a=%0h want 0/1/0", bus.rvfi_rd_wdata, bus.rvfi_load_regfile, bus.rvfi_rd_addr);
        end
        drive(1'b0, 32'h64, 32'h68, 1'b0);
        bus.wb_rd_addr   = 5'd5;
        bus.wb_rd_wdata  = 32'h1234_5678;
        bus.wb_mem_addr  = 32'h0000_1000;
        bus.wb_mem_wmask = 4'b0011;
        bus.wb_rs1_rdata = 32'hCAFE_0001;
        step();
        asserts++;
        if (bus.rvfi_rd_wdata !== 32'h1234_5678 || bus.rvfi_mem_addr !== 32'h1000 || bus.rvfi_mem_wmask !== 4'b0011 || bus.rvfi_rs1_rdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL rd_pass: got w=%0h a=%0h m=%0h r=%0h want 12345678/1000/3/cafe0001", bus.rvfi_rd_wdata, bus.rvfi_mem_addr, bus.rvfi_mem_wmask, bus.rvfi_rs1_rdata);
        end
        #2;
        rst = 1'b0;
        #1;
        asserts++;
        if (bus.rvfi_commit !== 1'b0 || bus.rvfi_order !== 64'd0 || bus.rvfi_rd_wdata !== 32'd0 || bus.rvfi_pc_rdata !== 32'd0) begin
            failures++; $display("FAIL async_reset: got c=%0h o=%0h w=%0h pc=%0h want 0/0/0/0", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_rd_wdata, bus.rvfi_pc_rdata);
        end
        step();
        rst = 1'b1;
        idle();
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b0) begin
            failures++; $display("FAIL reset_drop: got %0h want 0", bus.rvfi_commit);
        end
        drive(1'b0, 32'h60, 32'h64, 1'b0);
        step();
        asserts++;
        if (bus.rvfi_commit !== 1'b1 || bus.rvfi_order !== 64'd0 || bus.rvfi_errcode !== 16'd0) begin
            failures++; $display("FAIL post_reset: got c=%0h o=%0h e=%0h want 1/0/0", bus.rvfi_commit, bus.rvfi_order, bus.rvfi_errcode);
        end
        idle();
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        rst      = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_continuity();
        test_trap();
        test_halt();
        test_loop_break();
        test_flush();
        test_rd_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
